key_matrix_encoder: RTL and testbench
=====================================

// Module: key_matrix_encoder
// PURPOSE
//   Scans a 4x4 active-low keypad matrix and produces the 7-bit key code that feeds the
//   computer's memory-mapped keyboard input (inPKey). It is the producer end of that interface.
//   Each debounced key is reported as its ASCII code. The code reads 0 while no key is held.
// PARAMETERS
//   SCAN_DIV        1000  clock cycles per row (settle + sample); legal range >= 4
//   DEBOUNCE_SCANS  4     consecutive identical full-matrix frames before key_code changes; >= 1
// PORTS
//   clk        input   1  system clock
//   rst        input   1  synchronous, active-high reset
//   row_n      output  4  row drive, active low; exactly one bit low at any time
//   col_n      input   4  column sense, active low (external pull-ups); asynchronous to clk
//   key_code   output  7  debounced ASCII code of the held key, 0 = none; connects to inPKey
//   key_press  output  1  one-cycle pulse when key_code changes to a nonzero value
// BEHAVIOUR
//   Reset (sync, active-high; takes effect at the next edge even mid-scan):
//     - row_n=4'b1110, row=0, div=0, state=SCAN
//     - col synchroniser=4'b1111, frame_hit=0, candidate=0, stable=0
//     - key_code=0, key_press=0
//   Synchroniser: col_n passes through 2 flops. All sampling uses the synchronised value.
//   Divider: div is $clog2(SCAN_DIV) bits wide and counts 0..SCAN_DIV-1 in SCAN.
//   FSM SCAN: div increments each cycle. When div==SCAN_DIV-1:
//     - sample the synchronised columns for the current row;
//     - set div=0, row=row+1 (wrap 3->0), and rotate row_n left (1110->1101->1011->0111->1110);
//     - if the sampled row was row 3, go to EVAL.
//   FSM EVAL: lasts exactly 1 cycle, with row_n=4'b1110 held. It then returns to SCAN with row=0, div=0.
//     Frame period = 4*SCAN_DIV+1 cycles.
//   Key index = row*4+col. Within a frame, only the first pressed index is kept (lowest row, then
//     lowest col); later presses are ignored. frame_hit and the frame index clear on entry to SCAN row 0.
//   Code map, row-major:
//     row 0: '1'49  '2'50  '3'51  'A'65
//     row 1: '4'52  '5'53  '6'54  'B'66
//     row 2: '7'55  '8'56  '9'57  'C'67
//     row 3: '*'42  '0'48  '#'35  'D'68
//     frame_code=0 if no hit.
//   EVAL debounce:
//     - if frame_code==candidate: stable_n = min(stable+1, DEBOUNCE_SCANS);
//       else candidate<=frame_code and stable_n=1;
//     - if stable_n==DEBOUNCE_SCANS and candidate_next!=key_code: key_code<=candidate_next,
//       and key_press<=1 if candidate_next!=0.
//     - key_press is 0 in every other cycle; never high two cycles in a row.
//   Key change: key_code may change directly from one nonzero code to another; a pulse is issued.
//     Release (->0) never pulses.
//   Latency: key_code updates at the EVAL edge of the DEBOUNCE_SCANS-th consistent frame.
//   Holding a key indefinitely: stable saturates, with no further updates or pulses.
// TESTING (SCAN_DIV=8, DEBOUNCE_SCANS=2; frame = 33 cycles)
//   1 rst 1 cycle, col_n=1111 -> row_n=1110, key_code=0, key_press=0; row_n=1101 8 cycles after
//     rst low; EVAL every 33 cycles.
//   2 pull col_n[1] low while row_n==1101 ('5') for 3 frames -> key_code=53 at the 2nd frame's
//     EVAL; exactly one key_press pulse.
//   3 release after test 2 -> key_code=0 at the 2nd empty frame's EVAL, key_press stays 0.
//   4 press '#' (row 3, col 2) for 1 frame only, then release -> key_code stays 0, no pulse
//     (bounce rejected).
//   5 hold '1' and 'D' together for 2 frames -> key_code=49; then release '1', keep 'D' ->
//     key_code=68 two frames later with one pulse.
//   6 hold '9', assert rst mid-row-2 -> next edge: key_code=0, row_n=1110; after release,
//     key_code=57 at the 2nd full frame's EVAL.

Source files
------------

// File: rtl/key_matrix_encoder.sv
// 4x4 active-low keypad scanner: one row driven low per SCAN_DIV cycles, first pressed key per
// frame is kept, and a debounced ASCII code (0 = none) is presented on key_code.
module key_matrix_encoder #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [6:0] key_code,
  output logic       key_press
);

  localparam int DivW    = $clog2(SCAN_DIV);
  localparam int StableW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0]    DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [StableW-1:0] StableMax = StableW'(DEBOUNCE_SCANS);

  typedef enum logic {SCAN, EVAL} scanState_e;

  scanState_e         state, stateNext;
  logic [DivW-1:0]    div;
  logic [1:0]         row;
  logic [3:0]         colMeta, colSync;
  logic               frameHit;
  logic [3:0]         frameIdx;
  logic [6:0]         candidate, candidateNext;
  logic [StableW-1:0] stable, stableNext;
  logic [6:0]         frameCode;
  logic [1:0]         firstCol;
  logic               divEnd, rowHit, update;

  function automatic logic [6:0] codeOf(input logic [3:0] idx);
    case (idx)
      4'd0:  codeOf = 7'd49;  4'd1:  codeOf = 7'd50;  4'd2:  codeOf = 7'd51;  4'd3:  codeOf = 7'd65;
      4'd4:  codeOf = 7'd52;  4'd5:  codeOf = 7'd53;  4'd6:  codeOf = 7'd54;  4'd7:  codeOf = 7'd66;
      4'd8:  codeOf = 7'd55;  4'd9:  codeOf = 7'd56;  4'd10: codeOf = 7'd57;  4'd11: codeOf = 7'd67;
      4'd12: codeOf = 7'd42;  4'd13: codeOf = 7'd48;  4'd14: codeOf = 7'd35;  default: codeOf = 7'd68;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= SCAN;
    else     state <= stateNext;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    divEnd    = (div == DivLast);
    case (state)
      SCAN:    if (divEnd && row == 2'd3) stateNext = EVAL;
      default: stateNext = SCAN;
    endcase
  end

  // Lowest pressed column of the row currently being sensed.
  always_comb begin
    firstCol = 2'd0;
    rowHit   = (colSync != 4'hF);
    for (int c = 3; c >= 0; c--) begin
      if (!colSync[c]) firstCol = 2'(c);
    end
  end

  always_comb begin
    frameCode = frameHit ? codeOf(frameIdx) : 7'd0;
    if (frameCode == candidate) begin
      candidateNext = candidate;
      stableNext    = (stable == StableMax) ? StableMax : stable + 1'b1;
    end else begin
      candidateNext = frameCode;
      stableNext    = StableW'(1);
    end
    update = (stableNext == StableMax) && (candidateNext != key_code);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_n     <= 4'b1110;
      row       <= 2'd0;
      div       <= '0;
      colMeta   <= 4'hF;
      colSync   <= 4'hF;
      frameHit  <= 1'b0;
      frameIdx  <= 4'd0;
      candidate <= 7'd0;
      stable    <= '0;
      key_code  <= 7'd0;
      key_press <= 1'b0;
    end else begin
      colMeta   <= col_n;
      colSync   <= colMeta;
      key_press <= 1'b0;
      case (state)
        SCAN: begin
          div <= divEnd ? '0 : div + 1'b1;
          if (divEnd) begin
            row   <= row + 1'b1;
            row_n <= {row_n[2:0], row_n[3]};
            if (!frameHit && rowHit) begin
              frameHit <= 1'b1;
              frameIdx <= {row, firstCol};
            end
          end
        end
        default: begin
          // EVAL: row_n already wrapped to 1110 and row to 0; clear the frame for the next scan.
          div       <= '0;
          frameHit  <= 1'b0;
          candidate <= candidateNext;
          stable    <= stableNext;
          if (update) begin
            key_code  <= candidateNext;
            key_press <= (candidateNext != 7'd0);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_matrix_encoder.sv
// Bench for key_matrix_encoder: keypad model driving col_n from row_n, frame-level reference
// model of the debounced key code, checked every cycle.
module tb_key_matrix_encoder;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 2;
  localparam int FRAME    = 4 * SCAN_DIV + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [6:0] key_code;
  logic       key_press;

  logic [15:0] pressed = 16'h0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          n = 0;
  int          hist[$];
  logic [6:0]  expKey   = 7'd0;
  logic        expPress = 1'b0;
  int          codeTab[16] = '{49, 50, 51, 65, 52, 53, 54, 66, 55, 56, 57, 67, 42, 48, 35, 68};

  key_matrix_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_press(key_press)
  );

  always #5 clk = ~clk;

  // Passive keypad: a held key shorts its column to the driven (low) row.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row_n[r] == 1'b0) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[r*4+c]) col_n[c] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] expRow(input int cnt);
    int p;
    int r;
    p = cnt % FRAME;
    r = (p < 4 * SCAN_DIV) ? p / SCAN_DIV : 0;
    expRow = ~(4'b0001 << r);
  endfunction

  // Debounced key = code of the last DEB frames when they all agree.
  task automatic evalFrame();
    int  code;
    bit  same;
    code = 0;
    for (int i = 0; i < 16; i++) begin
      if (pressed[i]) begin
        code = codeTab[i];
        break;
      end
    end
    hist.push_back(code);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != code) same = 1'b0;
      if (same && code != int'(expKey)) begin
        expKey   = 7'(code);
        expPress = (code != 0);
      end
    end
  endtask

  task automatic tick(input bit doRst);
    rst = doRst;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (doRst) begin
      n = 0;
      hist.delete();
      expKey   = 7'd0;
      expPress = 1'b0;
    end else begin
      n++;
      expPress = 1'b0;
      if (n % FRAME == 0) evalFrame();
    end
    check("row_n", {28'd0, row_n}, {28'd0, expRow(n)});
    check("key_code", {25'd0, key_code}, {25'd0, expKey});
    check("key_press", {31'd0, key_press}, {31'd0, expPress});
  endtask

  // Called only at a frame boundary; keys change only between frames.
  task automatic runFrames(input logic [15:0] mask, input int frames);
    pressed = mask;
    repeat (frames * FRAME) tick(1'b0);
  endtask

  task automatic midReset(input int offset);
    repeat (offset) tick(1'b0);
    tick(1'b1);
  endtask

  initial begin
    logic [15:0] mask;
    int          sel;

    tick(1'b1);
    runFrames(16'h0, 2);                        // idle scan timing
    runFrames(16'h1 << 5, 3);                   // '5' held
    runFrames(16'h0, 3);                        // release
    runFrames(16'h1 << 14, 1);                  // '#' bounce
    runFrames(16'h0, 2);
    runFrames((16'h1 << 0) | (16'h1 << 15), 2); // '1' + 'D'
    runFrames(16'h1 << 15, 2);                  // 'D' alone
    runFrames(16'h0, 2);
    runFrames(16'h1 << 10, 1);                  // '9' held across reset
    midReset(2 * SCAN_DIV + 4);
    runFrames(16'h1 << 10, 3);
    runFrames(16'h0, 2);

    for (int seg = 0; seg < 40; seg++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 2)      mask = 16'h0;
      else if (sel <= 7) mask = 16'h1 << $urandom_range(0, 15);
      else               mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        pressed = mask;
        midReset($urandom_range(1, FRAME - 1));
      end
      runFrames(mask, $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
